// File: rtl/mix_shift_pkg.sv
// Shared definitions for the MIX shift-class instruction sequencer.
// Field codes, word geometry and the sequencer state encoding.
package mix_shift_pkg;

    localparam int WORD_W  = 31;
    localparam int BYTE_W  = 6;
    localparam int M_W     = 12;
    localparam int FIELD_W = 6;

    localparam logic [FIELD_W-1:0] F_SLA  = 6'd0;
    localparam logic [FIELD_W-1:0] F_SRA  = 6'd1;
    localparam logic [FIELD_W-1:0] F_SLAX = 6'd2;
    localparam logic [FIELD_W-1:0] F_SRAX = 6'd3;
    localparam logic [FIELD_W-1:0] F_SLC  = 6'd4;
    localparam logic [FIELD_W-1:0] F_SRC  = 6'd5;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WB,
        FIN
    } state_t;

    function automatic logic field_legal(input logic [FIELD_W-1:0] f);
        return f <= F_SRC;
    endfunction

    // SLA/SRA touch rA only; every other legal shift also rewrites rX.
    function automatic logic writes_x(input logic [FIELD_W-1:0] f);
        return (f >= F_SLAX) && (f <= F_SRC);
    endfunction

endpackage

// File: rtl/mix_shift_ctrl.sv
// Sequencer for MIX shift instructions: snapshots operands, launches the
// shift unit, waits for its stop strobe under a watchdog, then writes back.
module mix_shift_ctrl
    import mix_shift_pkg::*;
#(
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [5:0]        field,
    input  logic              m_sign,
    input  logic [11:0]       m_mag,
    input  logic [30:0]       ra_in,
    input  logic [30:0]       rx_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              ra_we,
    output logic              rx_we,
    output logic [30:0]       ra_wdata,
    output logic [30:0]       rx_wdata,
    output logic              sh_start,
    output logic [5:0]        sh_field,
    output logic [11:0]       sh_m,
    output logic [30:0]       sh_ina,
    output logic [30:0]       sh_inx,
    input  logic [30:0]       sh_outa,
    input  logic [30:0]       sh_outx,
    input  logic              sh_stop
);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             capture, latch_res;
    logic             busy_nx, done_nx, err_nx, ra_we_nx, rx_we_nx, sh_start_nx;

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        err_nx    = 1'b0;
        capture   = 1'b0;
        latch_res = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    if (!field_legal(field)) begin
                        state_nx = FIN;
                        err_nx   = 1'b1;
                    end else if (m_sign) begin
                        state_nx = FIN;
                    end else begin
                        state_nx = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_nx = WAIT;
                cnt_nx   = '0;
            end
            WAIT: begin
                // sh_stop takes priority over an expiring watchdog
                if (sh_stop) begin
                    latch_res = 1'b1;
                    state_nx  = WB;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_nx = FIN;
                    err_nx   = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            WB:      state_nx = IDLE;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        // Outputs are decoded from the next state so they can be registered.
        busy_nx     = (state_nx != IDLE);
        sh_start_nx = (state_nx == ISSUE);
        done_nx     = (state_nx == WB) || (state_nx == FIN);
        ra_we_nx    = (state_nx == WB);
        rx_we_nx    = (state_nx == WB) && writes_x(sh_field);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            ra_we    <= 1'b0;
            rx_we    <= 1'b0;
            sh_start <= 1'b0;
            ra_wdata <= '0;
            rx_wdata <= '0;
            sh_field <= '0;
            sh_m     <= '0;
            sh_ina   <= '0;
            sh_inx   <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            err      <= err_nx;
            ra_we    <= ra_we_nx;
            rx_we    <= rx_we_nx;
            sh_start <= sh_start_nx;
            if (capture) begin
                sh_field <= field;
                sh_m     <= m_mag;
                sh_ina   <= ra_in;
                sh_inx   <= rx_in;
            end
            if (latch_res) begin
                ra_wdata <= sh_outa;
                rx_wdata <= sh_outx;
            end
        end
    end

endmodule

// File: tb/tb_mix_shift_ctrl.sv
// Directed bench for mix_shift_ctrl with a behavioural shift unit that
// stops two cycles after launch (or never, for the watchdog case).
module tb_mix_shift_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  field = '0;
    logic        m_sign = 1'b0;
    logic [11:0] m_mag = '0;
    logic [30:0] ra_in = '0;
    logic [30:0] rx_in = '0;
    logic        busy, done, err, ra_we, rx_we, sh_start, sh_stop;
    logic [30:0] ra_wdata, rx_wdata, sh_ina, sh_inx, sh_outa, sh_outx;
    logic [5:0]  sh_field;
    logic [11:0] sh_m;

    logic [1:0]  stop_pipe = '0;
    logic        stub_dead = 1'b0;
    logic        man_stop = 1'b0;

    int          n_chk = 0;
    int          n_err = 0;

    int          st_at, st_cnt, dn_at, dn_cnt, we_cnt;
    logic        err_seen, ra_we_seen, rx_we_seen;
    logic [31:0] busy_v;
    logic [30:0] got_a, got_x, saved_a;

    mix_shift_ctrl #(.TIMEOUT(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .field(field),
        .m_sign(m_sign), .m_mag(m_mag), .ra_in(ra_in), .rx_in(rx_in),
        .busy(busy), .done(done), .err(err), .ra_we(ra_we), .rx_we(rx_we),
        .ra_wdata(ra_wdata), .rx_wdata(rx_wdata), .sh_start(sh_start),
        .sh_field(sh_field), .sh_m(sh_m), .sh_ina(sh_ina), .sh_inx(sh_inx),
        .sh_outa(sh_outa), .sh_outx(sh_outx), .sh_stop(sh_stop)
    );

    always #5 clk = ~clk;

    function automatic logic [30:0] mkw(input logic s, input int b1, b2, b3, b4, b5);
        return {s, 6'(b1), 6'(b2), 6'(b3), 6'(b4), 6'(b5)};
    endfunction

    // Reference shift unit: byte shifts on rA / rA:rX, rotates reduced mod 10.
    function automatic logic [61:0] shift_model(input logic [5:0] f, input logic [11:0] m,
                                                input logic [30:0] ina, input logic [30:0] inx);
        logic [30:0] oa, ox;
        logic [29:0] a;
        logic [59:0] v;
        int          mi, r;
        oa = ina;
        ox = inx;
        a  = ina[29:0];
        v  = {ina[29:0], inx[29:0]};
        mi = int'(m);
        r  = mi % 10;
        case (f)
            6'd0: oa[29:0] = (mi >= 5) ? '0 : (a << (6 * mi));
            6'd1: oa[29:0] = (mi >= 5) ? '0 : (a >> (6 * mi));
            6'd2: v = (mi >= 10) ? '0 : (v << (6 * mi));
            6'd3: v = (mi >= 10) ? '0 : (v >> (6 * mi));
            6'd4: v = (v << (6 * r)) | (v >> (60 - 6 * r));
            6'd5: v = (v >> (6 * r)) | (v << (60 - 6 * r));
            default: ;
        endcase
        if (f >= 6'd2 && f <= 6'd5) begin
            oa[29:0] = v[59:30];
            ox[29:0] = v[29:0];
        end
        return {oa, ox};
    endfunction

    always_comb {sh_outa, sh_outx} = shift_model(sh_field, sh_m, sh_ina, sh_inx);

    always @(posedge clk) stop_pipe <= {stop_pipe[0], sh_start & ~stub_dead};
    assign sh_stop = stop_pipe[1] | man_stop;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start in cycle N and record what happens in cycles N+1..N+win.
    task automatic run_op(input logic [5:0] f, input logic ms, input logic [11:0] m,
                          input logic [30:0] a, input logic [30:0] x,
                          input int win, input int restart_at, input int rst_at);
        field = f; m_sign = ms; m_mag = m; ra_in = a; rx_in = x; start = 1'b1;
        st_at = 0; st_cnt = 0; dn_at = 0; dn_cnt = 0; we_cnt = 0;
        err_seen = 1'b0; ra_we_seen = 1'b0; rx_we_seen = 1'b0; busy_v = '0;
        for (int i = 1; i <= win; i++) begin
            tick();
            start = (i == restart_at);
            if (i == restart_at) begin
                field = 6'd5;
                m_mag = 12'd3;
            end
            if (i == rst_at) rst_n = 1'b0;
            if (i == rst_at + 1) rst_n = 1'b1;
            #1;
            if (sh_start) begin
                st_cnt++;
                if (st_at == 0) st_at = i;
            end
            if (done) begin
                dn_cnt++;
                dn_at = i;
                err_seen = err;
                ra_we_seen = ra_we;
                rx_we_seen = rx_we;
            end
            if (ra_we || rx_we) we_cnt++;
            if (i < 32) busy_v[i] = busy;
        end
        start = 1'b0;
        got_a = ra_wdata;
        got_x = rx_wdata;
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        repeat (3) tick();
        chk("rst_flags", 64'({busy, done, err, ra_we, rx_we, sh_start}), 64'(0));
        chk("rst_sh_ina", 64'(sh_ina), 64'(0));
        chk("rst_sh_field", 64'(sh_field), 64'(0));
        rst_n = 1'b1;
        repeat (2) tick();
        chk("idle_flags", 64'({busy, done, err, ra_we, rx_we, sh_start}), 64'(0));
        chk("idle_wdata", 64'(ra_wdata), 64'(0));

        // SLA 1
        run_op(6'd0, 1'b0, 12'd1, mkw(0, 1, 2, 3, 4, 5), mkw(0, 6, 7, 8, 9, 10), 6, 0, 0);
        chk("sla_st_at", 64'(st_at), 64'(1));
        chk("sla_st_cnt", 64'(st_cnt), 64'(1));
        chk("sla_dn_at", 64'(dn_at), 64'(4));
        chk("sla_dn_cnt", 64'(dn_cnt), 64'(1));
        chk("sla_we", 64'({err_seen, ra_we_seen, rx_we_seen}), 64'(3'b010));
        chk("sla_busy", 64'(busy_v[6:1]), 64'(6'b001111));
        chk("sla_ra", 64'(got_a), 64'(mkw(0, 2, 3, 4, 5, 0)));

        // SRAX 6
        run_op(6'd3, 1'b0, 12'd6, mkw(1, 1, 2, 3, 4, 5), mkw(0, 6, 7, 8, 9, 10), 6, 0, 0);
        chk("srax_dn_at", 64'(dn_at), 64'(4));
        chk("srax_we", 64'({err_seen, ra_we_seen, rx_we_seen}), 64'(3'b011));
        chk("srax_ra", 64'(got_a), 64'(mkw(1, 0, 0, 0, 0, 0)));
        chk("srax_rx", 64'(got_x), 64'(mkw(0, 0, 1, 2, 3, 4)));

        // SLC 11 (rotate by one byte)
        run_op(6'd4, 1'b0, 12'd11, mkw(0, 1, 2, 3, 4, 5), mkw(0, 6, 7, 8, 9, 10), 6, 0, 0);
        chk("slc_we", 64'({err_seen, ra_we_seen, rx_we_seen}), 64'(3'b011));
        chk("slc_ra", 64'(got_a), 64'(mkw(0, 2, 3, 4, 5, 6)));
        chk("slc_rx", 64'(got_x), 64'(mkw(0, 7, 8, 9, 10, 1)));
        chk("slc_sh_m", 64'(sh_m), 64'(11));

        // SRA 0 is issued normally and leaves rA unchanged
        run_op(6'd1, 1'b0, 12'd0, mkw(1, 9, 8, 7, 6, 5), mkw(0, 1, 1, 1, 1, 1), 6, 0, 0);
        chk("sra0_st_at", 64'(st_at), 64'(1));
        chk("sra0_dn_at", 64'(dn_at), 64'(4));
        chk("sra0_we", 64'({err_seen, ra_we_seen, rx_we_seen}), 64'(3'b010));
        chk("sra0_ra", 64'(got_a), 64'(mkw(1, 9, 8, 7, 6, 5)));

        // Illegal field
        run_op(6'd7, 1'b0, 12'd1, mkw(0, 1, 2, 3, 4, 5), mkw(0, 6, 7, 8, 9, 10), 6, 0, 0);
        chk("ill_dn_at", 64'(dn_at), 64'(1));
        chk("ill_st_cnt", 64'(st_cnt), 64'(0));
        chk("ill_err", 64'({err_seen, ra_we_seen, rx_we_seen}), 64'(3'b100));
        chk("ill_we_cnt", 64'(we_cnt), 64'(0));
        chk("ill_busy", 64'(busy_v[3:1]), 64'(3'b001));
        chk("ill_sh_field", 64'(sh_field), 64'(7));

        // Negative count is a NOP
        run_op(6'd0, 1'b1, 12'd2, mkw(0, 1, 2, 3, 4, 5), mkw(0, 6, 7, 8, 9, 10), 6, 0, 0);
        chk("nop_dn_at", 64'(dn_at), 64'(1));
        chk("nop_st_cnt", 64'(st_cnt), 64'(0));
        chk("nop_err", 64'({err_seen, ra_we_seen, rx_we_seen}), 64'(3'b000));

        // Watchdog: WAIT entered at N+2, abort TIMEOUT cycles later
        stub_dead = 1'b1;
        run_op(6'd2, 1'b0, 12'd1, mkw(0, 1, 2, 3, 4, 5), mkw(0, 6, 7, 8, 9, 10), 13, 0, 0);
        stub_dead = 1'b0;
        chk("to_st_cnt", 64'(st_cnt), 64'(1));
        chk("to_dn_at", 64'(dn_at), 64'(10));
        chk("to_dn_cnt", 64'(dn_cnt), 64'(1));
        chk("to_err", 64'({err_seen, ra_we_seen, rx_we_seen}), 64'(3'b100));
        chk("to_we_cnt", 64'(we_cnt), 64'(0));

        // Second start while busy is dropped
        run_op(6'd3, 1'b0, 12'd6, mkw(1, 1, 2, 3, 4, 5), mkw(0, 6, 7, 8, 9, 10), 8, 2, 0);
        chk("rs_dn_cnt", 64'(dn_cnt), 64'(1));
        chk("rs_st_cnt", 64'(st_cnt), 64'(1));
        chk("rs_dn_at", 64'(dn_at), 64'(4));
        chk("rs_sh_field", 64'(sh_field), 64'(3));
        chk("rs_rx", 64'(got_x), 64'(mkw(0, 0, 1, 2, 3, 4)));

        // Reset mid-operation aborts silently
        run_op(6'd0, 1'b0, 12'd1, mkw(0, 1, 2, 3, 4, 5), mkw(0, 6, 7, 8, 9, 10), 6, 0, 2);
        chk("rm_dn_cnt", 64'(dn_cnt), 64'(0));
        chk("rm_we_cnt", 64'(we_cnt), 64'(0));
        chk("rm_busy", 64'(busy_v[6:2]), 64'(0));
        chk("rm_sh_ina", 64'(sh_ina), 64'(0));
        chk("rm_wdata", 64'(ra_wdata), 64'(0));

        run_op(6'd0, 1'b0, 12'd1, mkw(0, 1, 2, 3, 4, 5), mkw(0, 6, 7, 8, 9, 10), 6, 0, 0);
        chk("ar_dn_at", 64'(dn_at), 64'(4));
        chk("ar_ra", 64'(got_a), 64'(mkw(0, 2, 3, 4, 5, 0)));

        // Stray sh_stop in IDLE
        saved_a = ra_wdata;
        man_stop = 1'b1;
        tick();
        man_stop = 1'b0;
        tick();
        chk("idle_stop_flags", 64'({busy, done, err, ra_we, rx_we}), 64'(0));
        chk("idle_stop_ra", 64'(ra_wdata), 64'(saved_a));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
